range_seq_driver: RTL and testbench

//   Initiator side of the go/finish range protocol. Buffers up to DEPTH unsigned samples.
//   On start, replays them as one sequence: go with the first word, finish with the last.

---
 rtl/range_pkg.sv | 14 +
 rtl/range_seq_driver_sample_buffer.sv | 27 ++
 rtl/range_seq_driver.sv | 168 ++++++++++++++++
 tb/tb_range_seq_driver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/range_pkg.sv
// Shared definitions for the range-finder stimulus driver and its datapath.
package range_pkg;

    // Sequencer states of the initiator.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } drv_state_t;

    // Sample / range width shared with the range finder datapath.
    localparam int RANGE_WIDTH = 8;

endpackage

// File: rtl/range_seq_driver_sample_buffer.sv
// Sample store: one synchronous write port, one combinational read port.
// Storage is deliberately not reset; only the owner's count says what is valid.
module sample_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/range_seq_driver.sv
// Initiator of the go/finish range protocol. Buffers samples while idle,
// replays them as one sequence on start, then compares the responder's range
// with the locally tracked max - min.
//
// Handshake: there is no back-pressure. A sequence is go (first word) followed
// by one word per cycle up to finish (last word); range_in is sampled only in
// the finish cycle. start/wr_en/clear are accepted in IDLE only and are
// dropped (never queued) while busy.
module range_seq_driver
    import range_pkg::*;
#(
    parameter int WIDTH = RANGE_WIDTH,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] range_in,
    output logic             go,
    output logic             finish,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      count,
    output logic             full,
    output logic             len_error,
    output logic [WIDTH-1:0] range_captured,
    output logic [WIDTH-1:0] expected_range,
    output logic             mismatch,
    output drv_state_t       state_dbg
);

    localparam int CW = AW + 1;

    drv_state_t       state_q, state_d;
    logic [AW:0]      count_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [WIDTH-1:0] run_max_q, run_min_q;
    logic [WIDTH-1:0] range_captured_q, expected_range_q;
    logic             mismatch_q;
    logic             len_error_q;

    logic             in_idle, in_send, at_last;
    logic             accept_start, refuse_start, wr_fire;
    logic [WIDTH-1:0] buf_rdata, hi_val, lo_val, final_range;

    assign in_idle = (state_q == IDLE);
    assign in_send = (state_q == SEND);
    assign full    = (count_q == CW'(DEPTH));
    assign at_last = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));

    // A 1-word sequence would need go and finish together, so it is refused.
    assign accept_start = in_idle && start && (count_q >= CW'(2));
    assign refuse_start = in_idle && start && (count_q <  CW'(2));
    // An accepted start freezes the buffer so the replayed length is the one
    // seen at launch.
    assign wr_fire = in_idle && !clear && wr_en && !full && !accept_start;

    sample_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clock   (clock),
        .we_i    (wr_fire),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (buf_rdata)
    );

    // Running extrema including the word on the bus this cycle.
    assign hi_val      = (buf_rdata > run_max_q) ? buf_rdata : run_max_q;
    assign lo_val      = (buf_rdata < run_min_q) ? buf_rdata : run_min_q;
    assign final_range = hi_val - lo_val;

    // Next-state selection for the IDLE -> SEND -> DONE loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_start) state_d = SEND;
            SEND:    if (at_last)      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Fill level: cleared or appended only while idle and not launching.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (in_idle && !accept_start) begin
            if (clear)        count_q <= '0;
            else if (wr_fire) count_q <= count_q + CW'(1);
        end
    end

    // Read pointer walks the buffer once per SEND cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
        end else if (accept_start) begin
            rd_ptr_q <= '0;
        end else if (in_send) begin
            rd_ptr_q <= at_last ? '0 : rd_ptr_q + AW'(1);
        end
    end

    // Min/max tracker, seeded by the go word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_max_q <= '0;
            run_min_q <= '0;
        end else if (in_send) begin
            if (rd_ptr_q == '0) begin
                run_max_q <= buf_rdata;
                run_min_q <= buf_rdata;
            end else begin
                run_max_q <= hi_val;
                run_min_q <= lo_val;
            end
        end
    end

    // Checker: capture the responder at finish, hold the verdict until next start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            range_captured_q <= '0;
            expected_range_q <= '0;
            mismatch_q       <= 1'b0;
        end else if (accept_start) begin
            mismatch_q <= 1'b0;
        end else if (in_send && at_last) begin
            range_captured_q <= range_in;
            expected_range_q <= final_range;
            mismatch_q       <= (range_in != final_range);
        end
    end

    // One-cycle pulse for a refused start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) len_error_q <= 1'b0;
        else       len_error_q <= refuse_start;
    end

    // Protocol outputs are forced low outside SEND.
    assign data_out       = in_send ? buf_rdata : '0;
    assign go             = in_send && (rd_ptr_q == '0);
    assign finish         = in_send && at_last;
    assign busy           = !in_idle;
    assign done           = (state_q == DONE);
    assign count          = count_q;
    assign len_error      = len_error_q;
    assign range_captured = range_captured_q;
    assign expected_range = expected_range_q;
    assign mismatch       = mismatch_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_range_seq_driver.sv
// Directed bench for range_seq_driver: table of replay sequences plus
// hand-written sequences for refusal, full buffer, async reset and back-to-back runs.
module tb_range_seq_driver;
    import range_pkg::*;

    localparam int W = 8;
    localparam int D = 16;

    typedef struct packed {
        logic [15:0][7:0] s;
        logic [7:0]       n;
        logic [7:0]       rin;
        logic [7:0]       exp_rng;
        logic             exp_mm;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         wr_en, clear, start;
    logic [W-1:0] wr_data, range_in;
    logic         go, finish, busy, done, full, len_error, mismatch;
    logic [W-1:0] data_out, range_captured, expected_range;
    logic [4:0]   count;
    drv_state_t   state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    vec_t vecs[5];

    range_seq_driver #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .clear(clear), .start(start), .range_in(range_in), .go(go),
        .finish(finish), .data_out(data_out), .busy(busy), .done(done),
        .count(count), .full(full), .len_error(len_error),
        .range_captured(range_captured), .expected_range(expected_range),
        .mismatch(mismatch), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [15:0][7:0] s, input int n);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = s[i];
            tick();
        end
        wr_en = 1'b0;
        chk("load_count", count, n);
    endtask

    // Launch, walk the SEND cycles against the expected queue, check the verdict.
    // poke drives start/wr_en during busy cycles, which must be ignored.
    task automatic run_seq(input logic [15:0][7:0] s, input int n, input logic [7:0] rin,
                           input logic [7:0] exp_rng, input logic exp_mm, input logic poke);
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) exp_q.push_back(s[i]);
        range_in = rin;
        start    = 1'b1;
        tick();
        start   = poke;
        wr_en   = poke;
        wr_data = 8'h55;
        for (int i = 0; i < n; i++) begin
            w = exp_q.pop_front();
            chk("send_data", data_out, w);
            chk("send_go", go, (i == 0));
            chk("send_finish", finish, (i == n - 1));
            chk("send_busy", busy, 1);
            chk("send_done", done, 0);
            tick();
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_go", go, 0);
        chk("done_data", data_out, 0);
        chk("range_captured", range_captured, rin);
        chk("expected_range", expected_range, exp_rng);
        chk("mismatch", mismatch, exp_mm);
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        chk("after_done", done, 0);
        chk("after_busy", busy, 0);
        chk("after_count", count, n);
        chk("mismatch_held", mismatch, exp_mm);
    endtask

    initial begin
        logic [15:0][7:0] s;

        vecs[0] = '{s: {96'h0, 32'h07_02_09_05}, n: 4, rin: 8'd7, exp_rng: 8'd7,  exp_mm: 1'b0};
        vecs[1] = '{s: {96'h0, 32'h07_02_09_05}, n: 4, rin: 8'd6, exp_rng: 8'd7,  exp_mm: 1'b1};
        vecs[2] = '{s: {96'h0, 32'h00_00_FF_00}, n: 2, rin: 8'hFF, exp_rng: 8'hFF, exp_mm: 1'b0};
        vecs[3] = '{s: {96'h0, 32'h00_03_03_03}, n: 3, rin: 8'd0, exp_rng: 8'd0,  exp_mm: 1'b0};
        vecs[4] = '{s: {96'h0, 32'h00_00_14_0A}, n: 2, rin: 8'd9, exp_rng: 8'd10, exp_mm: 1'b1};

        reset = 1'b1; wr_en = 0; clear = 0; start = 0; wr_data = 0; range_in = 0;
        #3;
        chk("rst_go", go, 0);
        chk("rst_finish", finish, 0);
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_len_error", len_error, 0);
        chk("rst_captured", range_captured, 0);
        chk("rst_expected", expected_range, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_state", state_dbg, IDLE);
        @(posedge clock);
        #1 reset = 1'b0;

        // Table of replay sequences
        for (int v = 0; v < 5; v++) begin
            load(vecs[v].s, int'(vecs[v].n));
            run_seq(vecs[v].s, int'(vecs[v].n), vecs[v].rin, vecs[v].exp_rng, vecs[v].exp_mm, 1'b0);
        end

        // Refused start with one sample, then with an empty buffer
        s = '0;
        s[0] = 8'd42;
        load(s, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("len_err_pulse", len_error, 1);
        chk("len_err_busy", busy, 0);
        chk("len_err_go", go, 0);
        tick();
        chk("len_err_clear", len_error, 0);
        chk("len_err_busy2", busy, 0);
        chk("len_err_go2", go, 0);
        clear = 1'b1;
        wr_en = 1'b1;
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        chk("clear_wins", count, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("len_err_empty", len_error, 1);

        // Fill to DEPTH, overflow write dropped, full-length replay
        for (int i = 0; i < D; i++) s[i] = 8'(i * 3 + 1);
        load(s, D);
        chk("full_flag", full, 1);
        wr_en = 1'b1;
        wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        chk("full_drop_count", count, D);
        chk("full_flag_hold", full, 1);
        run_seq(s, D, 8'd45, 8'd45, 1'b0, 1'b0);

        // Asynchronous reset in the second SEND cycle
        s = '0;
        s[0] = 8'd4; s[1] = 8'd8; s[2] = 8'd1; s[3] = 8'd6;
        load(s, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_go", go, 1);
        tick();
        chk("rs_data2", data_out, 8'd8);
        #2 reset = 1'b1;
        #1;
        chk("rs_go0", go, 0);
        chk("rs_finish0", finish, 0);
        chk("rs_data0", data_out, 0);
        chk("rs_busy0", busy, 0);
        chk("rs_count0", count, 0);
        chk("rs_state", state_dbg, IDLE);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("rs_no_done", done, 0);
            chk("rs_no_busy", busy, 0);
            tick();
        end

        // Back-to-back replays, with start/wr_en poked during busy
        s = '0;
        s[0] = 8'h00; s[1] = 8'hFF;
        load(s, 2);
        run_seq(s, 2, 8'hFF, 8'hFF, 1'b0, 1'b1);
        run_seq(s, 2, 8'hFF, 8'hFF, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
